// File: rtl/simplecpu2_pkg.sv
// simplecpu2 shared definitions.
// Provides the fetch datapath widths, the instruction opcode encoding and
// the fetch-stage state encoding used by the fetch top and its queue.
package simplecpu2_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 16;

    typedef enum logic [3:0] {
        OP_LOAD  = 4'h0,
        OP_STORE = 4'h1,
        OP_ADD   = 4'h2,
        OP_LOADC = 4'h3,
        OP_SUBS  = 4'h4,
        OP_JMPZ  = 4'h5,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/simplecpu2_fetch_fifo.sv
// Instruction queue for the simplecpu2 fetch stage.
// Holds {instruction, pc} pairs. The head is read straight from registered
// storage, so it stays stable while nothing is popped.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_push, i_data   enqueue one entry
//   i_pop            dequeue the head
//   i_flush          drop all entries (wins over push)
//   o_head           current head entry
//   o_count          number of valid entries
//   o_full, o_empty  occupancy flags
module simplecpu2_fetch_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 26,
    parameter int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/simplecpu2_fetch.sv
// simplecpu2 instruction fetch stage.
// Owns the PC, issues sequential reads to a synchronous instruction memory,
// queues returned words and hands them to execute over valid/ready. Taken
// jumps from execute redirect the PC and flush stale words; an opcode 4'hF
// word stops fetching until the next redirect.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   o_imem_ren, o_imem_addr        memory read request (combinational)
//   i_imem_rdata                   memory data, one cycle after request
//   o_instr_valid/o_instr/o_instr_pc, i_instr_ready   queue head handshake
//   i_redirect_valid, i_redirect_target               taken jump
//   o_pc                           next sequential fetch address
//   o_halted                       fetch stopped on a halt word
//
// state   | meaning
// ST_RUN  | fetching sequentially while queue credit allows
// ST_HALT | halt word seen; no reads until a redirect
module simplecpu2_fetch
    import simplecpu2_pkg::*;
#(
    parameter int PC_W    = simplecpu2_pkg::PC_W,
    parameter int INSTR_W = simplecpu2_pkg::INSTR_W,
    parameter int DEPTH   = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic               o_imem_ren,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic               o_instr_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_instr_pc,
    input  logic               i_instr_ready,
    input  logic               i_redirect_valid,
    input  logic [PC_W-1:0]    i_redirect_target,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_halted
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int DATA_W = INSTR_W + PC_W;

    fetch_state_e        r_state;
    logic                r_halted;
    logic [PC_W-1:0]     r_pc;
    logic                r_inflight;     // an unkilled read returns next cycle
    logic [PC_W-1:0]     r_inflight_pc;

    logic [DATA_W-1:0]   w_head;
    logic [CNT_W-1:0]    w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic                w_halt_word;
    logic                w_issue;
    logic [CNT_W:0]      w_occupancy;

    assign w_pop = !w_empty && i_instr_ready;

    // Credit counts the queued words plus the one in flight, minus the one
    // leaving this cycle, so back-to-back issue is possible at DEPTH=2.
    assign w_occupancy = (CNT_W+1)'(w_count) + (CNT_W+1)'(r_inflight)
                         - (CNT_W+1)'(w_pop);

    assign w_push      = r_inflight && !i_redirect_valid && (!w_full || w_pop);
    assign w_halt_word = w_push &&
                         (opcode_e'(i_imem_rdata[INSTR_W-1 -: 4]) == OP_HALT);
    assign w_issue     = i_rst_n && (r_state == ST_RUN) && !i_redirect_valid &&
                         (w_occupancy < (CNT_W+1)'(DEPTH));

    // Request is combinational so a redirect reaches memory in its own cycle.
    assign o_imem_ren  = i_rst_n && (i_redirect_valid || w_issue);
    assign o_imem_addr = (i_rst_n && i_redirect_valid) ? i_redirect_target : r_pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_RUN;
            r_halted      <= 1'b0;
            r_pc          <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (i_redirect_valid) begin
            r_state       <= ST_RUN;
            r_halted      <= 1'b0;
            r_pc          <= i_redirect_target + PC_W'(1);
            r_inflight    <= 1'b1;
            r_inflight_pc <= i_redirect_target;
        end else begin
            if (w_issue) begin
                r_pc          <= r_pc + PC_W'(1);
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_pc;
            end else begin
                r_inflight    <= 1'b0;
            end
            // The read issued alongside the halt word is discarded.
            if (w_halt_word) begin
                r_state    <= ST_HALT;
                r_halted   <= 1'b1;
                r_inflight <= 1'b0;
            end
        end
    end

    simplecpu2_fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  ({i_imem_rdata, r_inflight_pc}),
        .i_pop   (w_pop),
        .i_flush (i_redirect_valid),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_instr_valid = !w_empty;
    assign o_instr       = w_head[PC_W +: INSTR_W];
    assign o_instr_pc    = w_head[PC_W-1:0];
    assign o_pc          = r_pc;
    assign o_halted      = r_halted;

endmodule

// File: tb/tb_simplecpu2_fetch.sv
module tb_simplecpu2_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ren;
    logic [9:0]  imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [9:0]  instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [9:0]  redirect_target;
    logic [9:0]  pc;
    logic        halted;

    logic [15:0] imem [1024];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_ren) imem_rdata <= imem[imem_addr];

    simplecpu2_fetch dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .o_imem_ren        (imem_ren),
        .o_imem_addr       (imem_addr),
        .i_imem_rdata      (imem_rdata),
        .o_instr_valid     (instr_valid),
        .o_instr           (instr),
        .o_instr_pc        (instr_pc),
        .i_instr_ready     (instr_ready),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .o_pc              (pc),
        .o_halted          (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs sampled at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ren"},   imem_ren,    0);
        check({tag, "_addr"},  imem_addr,   0);
        check({tag, "_valid"}, instr_valid, 0);
        check({tag, "_instr"}, instr,       0);
        check({tag, "_ipc"},   instr_pc,    0);
        check({tag, "_pc"},    pc,          0);
        check({tag, "_halt"},  halted,      0);
    endtask

    task automatic check_head(input string tag, input logic [9:0] exp_pc, input logic [15:0] exp_instr);
        check({tag, "_valid"}, instr_valid, 1);
        check({tag, "_ipc"},   instr_pc,    exp_pc);
        check({tag, "_instr"}, instr,       exp_instr);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = 16'h0000;
        imem[0]    = 16'h3000;
        imem[1]    = 16'h3101;
        imem[2]    = 16'h3200;
        imem[3]    = 16'h2001;
        imem[4]    = 16'h3304;
        imem[5]    = 16'h5000;
        imem[6]    = 16'hFFFF;
        imem[7]    = 16'h1234;
        imem[1023] = 16'h3FFF;

        rst_n           = 1'b0;
        instr_ready     = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;

        // Held in reset
        sample();
        check_reset_vals("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // cycle 0: first issue from address 0
        sample();
        check("c0_ren", imem_ren, 1);
        check("c0_addr", imem_addr, 0);
        check("c0_valid", instr_valid, 0);
        // cycle 1
        next_cycle(); sample();
        check("c1_valid", instr_valid, 0);
        check("c1_addr", imem_addr, 1);
        check("c1_pc", pc, 1);
        // cycles 2..5: one instruction per cycle
        next_cycle(); sample(); check_head("c2", 10'd0, 16'h3000);
        next_cycle(); sample(); check_head("c3", 10'd1, 16'h3101);
        next_cycle(); sample(); check_head("c4", 10'd2, 16'h3200);
        next_cycle(); sample(); check_head("c5", 10'd3, 16'h2001);

        // cycle 6: redirect to 3 while head pc 4 is accepted
        next_cycle();
        redirect_valid  = 1'b1;
        redirect_target = 10'd3;
        sample();
        check_head("c6", 10'd4, 16'h3304);
        check("c6_ren", imem_ren, 1);
        check("c6_addr", imem_addr, 3);
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        check("c7_valid", instr_valid, 0);
        check("c7_pc", pc, 4);
        check("c7_addr", imem_addr, 4);
        next_cycle(); sample(); check_head("c8", 10'd3, 16'h2001);
        next_cycle(); sample(); check_head("c9", 10'd4, 16'h3304);
        next_cycle(); sample(); check_head("c10", 10'd5, 16'h5000);
        check("c10_addr", imem_addr, 7);
        check("c10_ren", imem_ren, 1);
        // cycle 11: halt word presented, fetch stops
        next_cycle(); sample(); check_head("c11", 10'd6, 16'hFFFF);
        check("c11_halt", halted, 1);
        check("c11_ren", imem_ren, 0);
        check("c11_pc", pc, 8);
        next_cycle(); sample();
        check("c12_valid", instr_valid, 0);
        check("c12_ren", imem_ren, 0);
        check("c12_halt", halted, 1);
        next_cycle(); sample();
        check("c13_ren", imem_ren, 0);

        // cycle 14: redirect out of halt to 0
        next_cycle();
        redirect_valid  = 1'b1;
        redirect_target = 10'd0;
        sample();
        check("c14_ren", imem_ren, 1);
        check("c14_addr", imem_addr, 0);
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        check("c15_halt", halted, 0);
        check("c15_valid", instr_valid, 0);
        next_cycle(); sample(); check_head("c16", 10'd0, 16'h3000);

        // cycle 17: redirect to 1023, PC wraps
        next_cycle();
        redirect_valid  = 1'b1;
        redirect_target = 10'd1023;
        sample();
        check_head("c17", 10'd1, 16'h3101);
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        check("c18_valid", instr_valid, 0);
        check("c18_pc", pc, 0);
        next_cycle(); sample(); check_head("c19", 10'd1023, 16'h3FFF);
        next_cycle(); sample(); check_head("c20", 10'd0, 16'h3000);

        // fill the queue, then reset mid-stream
        next_cycle();
        instr_ready = 1'b0;
        sample();
        check("c21_ren", imem_ren, 0);
        check_head("c21", 10'd1, 16'h3101);
        next_cycle(); sample();
        check_head("c22", 10'd1, 16'h3101);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // restart with execute stalled
        sample();
        check("r0_ren", imem_ren, 1);
        check("r0_addr", imem_addr, 0);
        next_cycle(); sample();
        check("r1_addr", imem_addr, 1);
        next_cycle(); sample();
        check_head("r2", 10'd0, 16'h3000);
        check("r2_ren", imem_ren, 0);
        for (int c = 3; c <= 6; c++) begin
            next_cycle(); sample();
            check($sformatf("r%0d_ren", c), imem_ren, 0);
            check_head($sformatf("r%0d", c), 10'd0, 16'h3000);
        end
        next_cycle();
        instr_ready = 1'b1;
        sample();
        check_head("r7", 10'd0, 16'h3000);
        check("r7_addr", imem_addr, 2);
        check("r7_ren", imem_ren, 1);
        next_cycle(); sample(); check_head("r8", 10'd1, 16'h3101);
        next_cycle(); sample(); check_head("r9", 10'd2, 16'h3200);
        next_cycle(); sample(); check_head("r10", 10'd3, 16'h2001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simplecpu2_fetch.md
# simplecpu2_fetch

Instruction fetch stage for simplecpu2; sits directly upstream of the execute unit and between it and the instruction memory. It owns the program counter, issues sequential reads to the synchronous instruction memory, and buffers returned words in a small queue. It presents instructions to execute through a valid/ready handshake, and takes taken-JMPZ redirects back from execute, flushing stale words. It stops fetching after an illegal/halt word (opcode 4'hF) until redirected.

## Interface
- PC_W, 10, program-counter / instruction-memory address width
- INSTR_W, 16, instruction width
- DEPTH, 2, instruction queue entries (≥2)

- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- imem_ren  out  1  instruction-memory read enable
- imem_addr  out  PC_W  read address (valid when imem_ren)
- imem_rdata  in  INSTR_W  read data, valid the cycle after imem_ren
- instr_valid  out  1  queue head valid
- instr  out  INSTR_W  queue head instruction
- instr_pc  out  PC_W  address of queue head
- instr_ready  in  1  execute accepts head this cycle
- redirect_valid  in  1  taken jump from execute
- redirect_target  in  PC_W  jump destination
- pc  out  PC_W  next sequential fetch address (top-level debug pc)
- halted  out  1  fetch stopped on opcode 4'hF

## Operation
- State: RUN, HALT. Reset → RUN, pc=0, queue empty, no read in flight.
- Issue rule (RUN, no redirect): imem_ren=1, imem_addr=pc when count + inflight − pop < DEPTH; pc ← pc+1, modulo 2^PC_W (1023 → 0).
- Return: one cycle after issue, {imem_rdata, issued address} pushed to queue unless killed.
- Pop: instr_valid & instr_ready removes head.
- Halt: a pushed word with [15:12]=4'hF is enqueued normally; at that edge state → HALT, halted=1, no further issues. A read already in flight behind it is discarded.
- Redirect (any state): imem_ren=1, imem_addr=redirect_target in the same cycle; at edge queue cleared, in-flight return killed, pc ← target+1, state → RUN, halted=0. Redirect takes precedence over issue, push and halt entry.
- Simultaneous pop and redirect: handshake completes (head consumed), then flush.
- Simultaneous push and pop with queue full: allowed, count unchanged.
- imem_rdata is ignored when no unkilled read is in flight.

## Timing
- Reset values: imem_ren=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, pc=0, halted=0.
- Issue in cycle N → data on imem_rdata in N+1 → instr_valid in N+2 (2-cycle fetch latency).
- First instruction (addr 0) valid in the 3rd cycle after rst release (issue in cycle 0).
- Sustained throughput 1 instruction/cycle with instr_ready held high and DEPTH=2.
- Redirect in cycle N → target instruction valid in N+2; instr_valid=0 in N+1.
- Reset asserted mid-operation: all state cleared immediately (async); in-flight data dropped.
- instr, instr_pc stable while instr_valid=1 and instr_ready=0.

## Structure
- simplecpu2_pkg: PC_W, INSTR_W constants; opcode enum (LOAD=0, STORE=1, ADD=2, LOADC=3, SUBS=4, JMPZ=5, HALT=4'hF); fetch state enum.
- Sub-module fetch_fifo: parameterised DEPTH queue of {INSTR_W+PC_W} bits, push/pop/flush, count, full/empty; registered head output.
- Top: PC register, in-flight/kill flag, issue credit logic, RUN/HALT FSM.

## Test plan
- Reset release, imem = LOADC program 0x3000,0x3101,0x3200,0x2001, instr_ready=1 → instr_valid from cycle 2, instr_pc 0,1,2,3 on consecutive cycles, one per cycle.
- instr_ready=0 for 5 cycles → at most 2 queued, imem_ren drops, head 0x3000 held; release → no loss or duplication.
- Redirect to 3 in the cycle instr_pc=4 is accepted → next valid instr_pc=3 two cycles later, words from 5,6 never presented.
- Word 0xFFFF at addr 6 → presented with instr_pc=6, halted=1, no reads beyond addr 7; redirect to 0 → halted=0, fetch resumes at 0.
- Redirect to 1023, instr_ready=1 → instr_pc 1023 then 0, pc wraps.
- Assert rst mid-stream with queue full → outputs return to reset values immediately; restart fetches addr 0.
